// File: rtl/ibuf_pad_pkg.sv
// ibuf_pad_rx shared types: bus-ownership states
// and counter width helpers.
package ibuf_pad_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    TURN   = 2'd1,
    LISTEN = 2'd2
  } state_t;

  // Bits needed to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ibuf_pad_rx_sync.sv
// pad_sync: N-flop synchronizer / delay line.
// i_clk, i_rst_n (async low), i_d -> o_q.
module pad_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/ibuf_pad_rx.sv
// ibuf_pad_rx: pad receive path with sync, glitch
// filter, bus-turnaround tracking and contention flag.
// C/CLR_N clock+async reset; PAD raw pad; T/I local
// tri-state ctl/data; O filtered level, O_VALID in
// LISTEN, RISE/FALL edge pulses, MISMATCH contention.
module ibuf_pad_rx
  import ibuf_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int TURN_CYCLES = 2
) (
  input  logic C,
  input  logic CLR_N,
  input  logic PAD,
  input  logic T,
  input  logic I,
  output logic O,
  output logic O_VALID,
  output logic RISE,
  output logic FALL,
  output logic MISMATCH
);

  localparam int FW = cnt_w(FILTER_LEN);
  localparam int TW = cnt_w(TURN_CYCLES);
  localparam int SW = cnt_w(SYNC_STAGES);

  logic w_ps;
  logic w_id;

  pad_sync #(.STAGES(SYNC_STAGES)) u_pad (
    .i_clk   (C),
    .i_rst_n (CLR_N),
    .i_d     (PAD),
    .o_q     (w_ps)
  );

  // I delayed by the same depth so it lines up
  // with the synchronized pad level.
  pad_sync #(.STAGES(SYNC_STAGES)) u_idly (
    .i_clk   (C),
    .i_rst_n (CLR_N),
    .i_d     (I),
    .o_q     (w_id)
  );

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tcnt;
  logic [TW-1:0]   w_tcnt;
  logic [TW-1:0]   w_tinc;

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= TURN;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_tcnt  <= w_tcnt;
    end
  end

  always_comb begin
    w_next = r_state;
    w_tcnt = r_tcnt;
    w_tinc = r_tcnt + TW'(1);
    unique case (r_state)
      DRIVE: begin
        if (T) begin
          w_next = TURN;
          w_tcnt = '0;
        end
      end
      TURN: begin
        if (!T) begin
          w_next = DRIVE;
          w_tcnt = '0;
        end else if (w_tinc == TW'(TURN_CYCLES)) begin
          w_next = LISTEN;
          w_tcnt = '0;
        end else begin
          w_tcnt = w_tinc;
        end
      end
      LISTEN: begin
        if (!T) begin
          w_next = DRIVE;
        end
      end
      default: begin
        w_next = TURN;
        w_tcnt = '0;
      end
    endcase
  end

  // Glitch filter: O follows ps only after
  // FILTER_LEN consecutive differing samples.
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_finc;
  logic          w_fhit;
  logic          r_o;

  assign w_finc = r_fcnt + FW'(1);
  assign w_fhit = (w_ps != r_o) &&
                  (w_finc == FW'(FILTER_LEN));

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_fcnt <= '0;
      r_o    <= 1'b0;
    end else begin
      if (w_ps == r_o) begin
        r_fcnt <= '0;
      end else if (w_fhit) begin
        r_fcnt <= '0;
        r_o    <= w_ps;
      end else if (r_fcnt != FW'(FILTER_LEN)) begin
        r_fcnt <= w_finc;
      end
    end
  end

  // Settle count: ps/id still carry pre-drive
  // history for the first SYNC_STAGES cycles.
  logic [SW-1:0] r_scnt;
  logic          w_settled;
  logic          w_enter_drv;
  logic          w_stay_lsn;

  assign w_enter_drv = (w_next == DRIVE) &&
                       (r_state != DRIVE);
  assign w_settled   = r_scnt >= SW'(SYNC_STAGES - 1);
  assign w_stay_lsn  = (r_state == LISTEN) &&
                       (w_next == LISTEN);

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_scnt <= '0;
    end else if (w_enter_drv) begin
      r_scnt <= '0;
    end else if ((r_state == DRIVE) &&
                 (r_scnt != SW'(SYNC_STAGES))) begin
      r_scnt <= r_scnt + SW'(1);
    end
  end

  logic r_valid;
  logic r_rise;
  logic r_fall;
  logic r_mism;

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_valid <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_mism  <= 1'b0;
    end else begin
      r_valid <= (w_next == LISTEN);
      r_rise  <= w_stay_lsn && w_fhit && w_ps;
      r_fall  <= w_stay_lsn && w_fhit && !w_ps;
      r_mism  <= (r_state == DRIVE) &&
                 (w_next == DRIVE) &&
                 w_settled && (w_ps != w_id);
    end
  end

  assign O        = r_o;
  assign O_VALID  = r_valid;
  assign RISE     = r_rise;
  assign FALL     = r_fall;
  assign MISMATCH = r_mism;

endmodule

// File: tb/tb_ibuf_pad_rx.sv
// Scoreboard bench for ibuf_pad_rx: default and
// swept-parameter instances vs a history model.
module tb_ibuf_pad_rx;

  logic C = 1'b0;
  logic CLR_N;
  logic PAD;
  logic T;
  logic I;

  logic o0, v0, r0, f0, m0;
  logic o1, v1, r1, f1, m1;

  always #5 C = ~C;

  ibuf_pad_rx u0 (
    .C(C), .CLR_N(CLR_N), .PAD(PAD), .T(T), .I(I),
    .O(o0), .O_VALID(v0), .RISE(r0), .FALL(f0),
    .MISMATCH(m0)
  );

  ibuf_pad_rx #(
    .SYNC_STAGES(3), .FILTER_LEN(1), .TURN_CYCLES(1)
  ) u1 (
    .C(C), .CLR_N(CLR_N), .PAD(PAD), .T(T), .I(I),
    .O(o1), .O_VALID(v1), .RISE(r1), .FALL(f1),
    .MISMATCH(m1)
  );

  localparam int MAXN = 8192;
  int sp[2] = '{2, 3};
  int fp[2] = '{3, 1};
  int tp[2] = '{2, 1};

  bit pad_h[MAXN];
  bit i_h[MAXN];
  int n;
  int run1;
  int run0;
  bit o_prev[2];
  bit v_prev[2];
  int lastchg[2];

  typedef struct {
    logic [9:0] e;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int ncyc = 0;

  function automatic bit ph(int k);
    return (k < 0) ? 1'b0 : pad_h[k];
  endfunction

  function automatic bit ih(int k);
    return (k < 0) ? 1'b0 : i_h[k];
  endfunction

  task automatic model_reset();
    n = 0;
    run1 = 1;
    run0 = 0;
    for (int d = 0; d < 2; d++) begin
      o_prev[d]  = 1'b0;
      v_prev[d]  = 1'b0;
      lastchg[d] = -1;
    end
  endtask

  task automatic chk(string nm, int d,
                     logic a, logic e, int cy);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s[%0d] cyc %0d got %b want %b",
                  nm, d, cy, a, e);
  endtask

  // Reference: filter = F consecutive opposite
  // samples since last change; valid = enough
  // released cycles; contention after settle.
  initial begin
    model_reset();
    forever begin
      @(posedge C);
      ncyc++;
      if (!CLR_N) begin
        model_reset();
      end else begin
        exp_t x;
        x.e = '0;
        x.cyc = ncyc;
        pad_h[n] = PAD;
        i_h[n] = I;
        if (T) begin
          run1++;
          run0 = 0;
        end else begin
          run1 = 0;
          run0++;
        end
        for (int d = 0; d < 2; d++) begin
          bit v, o, fl, rs, fa, mm;
          v = (run1 >= tp[d] + 1);
          fl = (n - lastchg[d] >= fp[d]);
          for (int j = 0; j < fp[d]; j++)
            if (ph(n - sp[d] - j) == o_prev[d])
              fl = 1'b0;
          o = fl ? !o_prev[d] : o_prev[d];
          if (fl) lastchg[d] = n;
          rs = v && v_prev[d] && o && !o_prev[d];
          fa = v && v_prev[d] && !o && o_prev[d];
          mm = (run0 >= sp[d] + 1) &&
               (ph(n - sp[d]) != ih(n - sp[d]));
          x.e[d*5 +: 5] = {o, v, rs, fa, mm};
          o_prev[d] = o;
          v_prev[d] = v;
        end
        exp_q.push_back(x);
        n++;
      end
    end
  end

  string nm[5] = '{"mism", "fall", "rise",
                   "o_valid", "o"};

  initial begin
    forever begin
      @(negedge C);
      if (!CLR_N) begin
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        exp_t x;
        logic [9:0] a;
        x = exp_q.pop_front();
        a = {o1, v1, r1, f1, m1, o0, v0, r0, f0, m0};
        for (int d = 0; d < 2; d++)
          for (int b = 0; b < 5; b++)
            chk(nm[b], d, a[d*5+b], x.e[d*5+b], x.cyc);
      end
    end
  end

  task automatic cyc(bit p, bit t, bit i);
    PAD = p;
    T = t;
    I = i;
    @(posedge C);
    #2;
  endtask

  task automatic rep(int k, bit p, bit t, bit i);
    repeat (k) cyc(p, t, i);
  endtask

  task automatic async_reset();
    logic [9:0] a;
    #1;
    CLR_N = 1'b0;
    #1;
    a = {o1, v1, r1, f1, m1, o0, v0, r0, f0, m0};
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 5; b++)
        chk({"rst_", nm[b]}, d, a[d*5+b], 1'b0, ncyc);
    @(posedge C);
    #2;
    CLR_N = 1'b1;
  endtask

  initial begin
    int hp, ht;
    bit rp, rt;
    CLR_N = 1'b0;
    PAD = 1'b0;
    T = 1'b1;
    I = 1'b0;
    repeat (2) @(posedge C);
    #2;
    CLR_N = 1'b1;
    // glitch then steady level
    rep(6, 0, 1, 0);
    rep(2, 1, 1, 0);
    rep(6, 0, 1, 0);
    rep(8, 1, 1, 0);
    rep(8, 0, 1, 0);
    // turnaround with pad high, reclaim early
    rep(4, 1, 0, 1);
    rep(5, 1, 1, 0);
    rep(3, 1, 0, 1);
    rep(1, 1, 1, 0);
    rep(4, 1, 0, 1);
    // contention
    rep(6, 0, 0, 1);
    rep(5, 1, 0, 1);
    rep(5, 1, 1, 0);
    // claim on the same edge O flips
    rep(8, 0, 1, 0);
    rep(4, 1, 1, 0);
    rep(4, 1, 0, 0);
    rep(5, 1, 1, 0);
    // reset with filter mid-count
    rep(8, 0, 1, 0);
    rep(4, 1, 1, 0);
    async_reset();
    rep(6, 1, 1, 0);
    // random traffic
    hp = 0;
    ht = 0;
    rp = 0;
    rt = 1;
    for (int k = 0; k < 2500; k++) begin
      if (hp == 0) begin
        rp = 1'($urandom);
        hp = $urandom_range(1, 6);
      end
      if (ht == 0) begin
        rt = 1'($urandom);
        ht = $urandom_range(1, 20);
      end
      hp--;
      ht--;
      if (k == 1200) async_reset();
      cyc(rp, rt, 1'($urandom));
    end
    rep(4, 0, 1, 0);
    @(negedge C);
    @(negedge C);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ibuf_pad_rx.md
# ibuf_pad_rx

Receive-side companion to the tri-state pad output buffers. It samples an asynchronous bidirectional pad, synchronizes and glitch-filters it, and tracks bus ownership from the local tri-state control so that received data is flagged valid only after a bus-turnaround delay. While the local driver owns the pad, it loops back the pad value and flags contention. It sits between the pad (IOB) and fabric logic, alongside the matching tri-state output buffer that shares the same `T` and `I`.

## Interface

Parameters:

- `SYNC_STAGES`, default 2: synchronizer flops on `PAD`, legal range ≥2.
- `FILTER_LEN`, default 3: consecutive stable synchronized samples required before `O` changes, legal range ≥1.
- `TURN_CYCLES`, default 2: cycles after release (`T` 0→1) before `O_VALID` asserts, legal range ≥1.

Ports:

- `C` input, 1 bit: clock, rising edge.
- `CLR_N` input, 1 bit: reset, asynchronous, active-low.
- `PAD` input, 1 bit: raw pad level; asynchronous to `C`.
- `T` input, 1 bit: local tri-state control; 0 = local driver enabled, 1 = released. Synchronous to `C`.
- `I` input, 1 bit: value the local driver puts on the pad; synchronous to `C`.
- `O` output, 1 bit: filtered, synchronized pad level.
- `O_VALID` output, 1 bit: high only in LISTEN state.
- `RISE` output, 1 bit: one-cycle pulse when `O` goes 0→1 while in LISTEN.
- `FALL` output, 1 bit: one-cycle pulse when `O` goes 1→0 while in LISTEN.
- `MISMATCH` output, 1 bit: one-cycle-per-cycle flag; synchronized pad ≠ aligned `I` while driving and settled.

## Operation

- Reset (`CLR_N`=0, any time, including mid-turnaround or mid-filter):
  - outputs `O`=0, `O_VALID`=0, `RISE`=0, `FALL`=0, `MISMATCH`=0;
  - synchronizer flops, `I` delay line, filter counter and turnaround counter are cleared;
  - state = TURN.
- Synchronizer: `PAD` passes through `SYNC_STAGES` flops, giving `ps`. `I` is delayed by `SYNC_STAGES` flops, giving `id`, aligned with `ps`.
- Glitch filter (runs in every state):
  - if `ps` = `O`, the counter clears to 0;
  - otherwise the counter increments;
  - when the counter would reach `FILTER_LEN`, `O` ← `ps` and the counter clears;
  - the counter saturates and never wraps.
- States:
  - DRIVE:
    - `O_VALID`=0;
    - `MISMATCH` = (`ps`≠`id`), gated off for the first `SYNC_STAGES` cycles after entry (settle count);
    - `T`=1 → TURN, turnaround counter cleared.
  - TURN:
    - `O_VALID`=0, `MISMATCH`=0;
    - `T`=0 → DRIVE (priority over the count);
    - otherwise the counter increments; when the count reaches `TURN_CYCLES` → LISTEN.
  - LISTEN:
    - `O_VALID`=1;
    - `RISE`/`FALL` pulse in the same cycle `O` changes;
    - `T`=0 → DRIVE next edge;
    - `O_VALID` drops with the state, with no extra cycle.
- Edge pulses:
  - only generated when the state is LISTEN both before and after the edge;
  - an `O` change on the TURN→LISTEN edge produces no pulse;
  - `RISE` and `FALL` are never high together.
- Simultaneous events: `T`=0 in LISTEN at the same edge the filter updates `O`. `O` still updates, the state goes to DRIVE, and no pulse is generated.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Pad-to-`O` latency: a `PAD` step stable before edge 0 appears on `O` after edge `SYNC_STAGES`+`FILTER_LEN`−1 (defaults: 4 edges).
- Any `PAD` pulse shorter than `FILTER_LEN` cycles after synchronization is suppressed.
- Release-to-valid latency: `T` 0→1 sampled at edge k gives `O_VALID`=1 after edge k+`TURN_CYCLES`.
- Claim-to-invalid latency: `T`=0 sampled at edge k gives `O_VALID`=0 after edge k.
- `MISMATCH`: earliest assertion is at edge `SYNC_STAGES` after DRIVE entry.

## Structure

- A shared package `ibuf_pad_pkg` holds:
  - the state enum (DRIVE, TURN, LISTEN);
  - `clog2`-based width helpers for the filter and turnaround counters.
- One sub-module, `pad_sync`: an N-stage synchronizer with async active-low clear. It is instantiated twice, for `PAD` and for the `I` delay.
- FSM, filter and edge logic live in the top module.

## Test plan

- Reset mid-activity:
  - stimulus: `CLR_N` pulsed low asynchronously while in LISTEN with the filter counter at 2;
  - required: all outputs 0 immediately; state TURN; with `T`=1, `O_VALID`=1 two edges after release of reset.
- Filter:
  - stimulus: in LISTEN with `PAD`=0, a 2-cycle high glitch, then `PAD`=1 held steady;
  - required: no change on `O` for the glitch; for the steady level, `O`=1 and `RISE`=1 for one cycle after exactly 4 edges.
- Turnaround:
  - stimulus: `T` goes 1 at edge 10; `PAD` already high;
  - required: `O_VALID`=1 after edge 12; no `RISE`.
  - stimulus: `T`=0 at edge 11;
  - required: state DRIVE; `O_VALID` stays 0.
- Contention:
  - stimulus: DRIVE with `I`=1 and `PAD` forced 0;
  - required: `MISMATCH`=1 from edge 2 after DRIVE entry, every cycle.
  - stimulus: `PAD`=1;
  - required: `MISMATCH` clears 2 edges later.
- Simultaneous events:
  - stimulus: `T`=0 at the same edge the filter flips `O` 0→1 in LISTEN;
  - required: `O`=1, `O_VALID`=0, `RISE`=0.
- Parameter sweep:
  - `SYNC_STAGES`=3, `FILTER_LEN`=1, `TURN_CYCLES`=1;
  - required: pad-to-`O` latency = 3 edges; release-to-valid latency = 1 edge.
